ahb_sram_responder: RTL and testbench
=====================================

Name: ahb_sram_responder

Overview:
AHB-Lite subordinate that terminates the data-bus transfers issued by the EX/MA stages: word-organised SRAM, configurable wait states, byte-lane writes and ERROR responses. It serves as the core's data memory in simulation and FPGA builds, and it lets the bench exercise MA-stage stall and error paths.

Parameters:
DEPTH, 1024, memory size in 32-bit words; power of two, at least 4
BASE, 32'h0000_0000, byte base address; must be aligned to DEPTH*4
WAITS, 0, wait cycles inserted before each OKAY data phase completes (0..15)

Ports:
s_clk_i  in  1  clock
s_resetn_i  in  1  asynchronous active-low reset
s_hsel_i  in  1  subordinate select
s_haddr_i  in  32  address-phase byte address
s_htrans_i  in  2  transfer type; only NONSEQ/SEQ (bit1=1) are active
s_hwrite_i  in  1  1 = write
s_hsize_i  in  3  0 = byte, 1 = half, 2 = word; larger values are illegal
s_hburst_i  in  3  ignored
s_hprot_i  in  4  ignored
s_hmastlock_i  in  1  ignored
s_hwdata_i  in  32  data-phase write data on natural byte lanes
s_hready_i  in  1  bus ready; qualifies the address phase
s_hrdata_o  out  32  read data, full word on natural lanes
s_hreadyout_o  out  1  data-phase completion
s_hresp_o  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset:
  - s_hreadyout_o = 1, s_hresp_o = 0, s_hrdata_o = 0.
  - FSM goes to IDLE. All data-phase registers are cleared.
  - Memory contents are not reset.
- Address-phase accept: s_hsel_i & s_htrans_i[1] & s_hready_i at a rising edge. On accept, register the address, size, write flag and a legality flag.
- Illegal transfer, if any of the following holds:
  - address outside [BASE, BASE+DEPTH*4)
  - hsize > 2
  - half with addr[0] = 1
  - word with addr[1:0] != 0
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: no active data phase. Drive hreadyout = 1, hresp = 0.
    - Legal accept with WAITS = 0 → DATA.
    - Legal accept with WAITS > 0 → WAIT, counter = WAITS.
    - Illegal accept → ERR1.
    - Otherwise stay in IDLE.
  - WAIT: hreadyout = 0, hresp = 0. Decrement the counter each cycle; when it reaches 1, → DATA.
  - DATA: hreadyout = 1, hresp = 0. This is the completing cycle. From DATA, a new accept is evaluated exactly as in IDLE (pipelined back-to-back transfers are allowed); with no accept → IDLE.
  - ERR1: hreadyout = 0, hresp = 1. Always → ERR2.
  - ERR2: hreadyout = 1, hresp = 1. Next state is evaluated as in IDLE. A transfer accepted in ERR2 is processed normally; no cancellation.
  - ERROR responses never insert WAITS cycles.
- Write: performed at the rising edge ending the DATA cycle.
  - Byte enables: byte → lane addr[1:0]; half → lanes {addr[1],0}, {addr[1],1}; word → all lanes.
  - Only the enabled lanes of mem[(addr-BASE)>>2] are updated. Illegal writes never modify memory.
- Read:
  - In DATA, s_hrdata_o = mem[word] combinationally. In all other states it is 0.
  - A read whose data phase directly follows a write to the same word returns the newly written bytes, because the write completes before the read data phase.
- Non-active transfers (IDLE/BUSY type, or hsel = 0) cause no state change; the response is zero-wait OKAY.
- Accept with s_hready_i = 0 is ignored. The master holds the address until hready is high.
- Asynchronous reset asserted mid-WAIT or mid-ERR1 aborts the transfer immediately; no memory write occurs.

Optional Feature:
AHB_RESP_RANDWAIT_EN:
- Defined: a 16-bit Fibonacci LFSR (taps 16, 14, 13, 11) reset to 16'hACE1 advances every clock. Each legal accept loads the wait counter with lfsr[3:0] & WAITS instead of WAITS. A result of 0 means zero-wait → DATA.
- Undefined: fixed WAITS, and no LFSR logic is present.

Test Plan:
- Word write 32'hDEAD_BEEF to 0x10, then word read of 0x10 with WAITS = 0 → write DATA cycle has hreadyout = 1, hresp = 0; read DATA cycle returns 32'hDEAD_BEEF.
- Byte write 8'h5A on lane 2 to 0x12 over word 0x11223344 at 0x10 → word read of 0x10 returns 0x115A3344.
- WAITS = 3, word read → hreadyout low for exactly 3 cycles, then high with data. A back-to-back second read is accepted in the DATA cycle and sees another 3 waits.
- Half write to 0x13 (misaligned) and word read of BASE+DEPTH*4 → each gives ERR1 (hreadyout = 0, hresp = 1) then ERR2 (hreadyout = 1, hresp = 1). Memory is unchanged.
- Write 0xCAFEF00D to 0x20 immediately followed (pipelined) by a read of 0x20 → read returns 0xCAFEF00D.
- Reset pulse during WAIT of a write with WAITS = 4 → hreadyout = 1 and hresp = 0 during reset. Target word keeps its old value; the next transfer completes normally.

Source files
------------

// File: rtl/ahb_sram_responder.sv
// AHB-Lite word-organised SRAM subordinate with fixed wait states, byte-lane writes and ERROR responses.
// Optional `AHB_RESP_RANDWAIT_EN: LFSR-masked pseudo-random wait count per legal transfer.
module ahb_sram_responder #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int unsigned WAITS = 0
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_hsel_i,
  input  logic [31:0] s_haddr_i,
  input  logic [1:0]  s_htrans_i,
  input  logic        s_hwrite_i,
  input  logic [2:0]  s_hsize_i,
  input  logic [2:0]  s_hburst_i,
  input  logic [3:0]  s_hprot_i,
  input  logic        s_hmastlock_i,
  input  logic [31:0] s_hwdata_i,
  input  logic        s_hready_i,
  output logic [31:0] s_hrdata_o,
  output logic        s_hreadyout_o,
  output logic        s_hresp_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] SPAN    = 32'(DEPTH) << 2;
  localparam logic [3:0]  WAITS_L = 4'(WAITS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      be_q, be_d;
  logic            write_q, write_d;
  logic            hreadyout_q, hreadyout_d;
  logic            hresp_q, hresp_d;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     off;
  logic            accept;
  logic            legal;
  logic [3:0]      be_in;
  logic [3:0]      load;
  logic            unused_ok;

  assign unused_ok = ^{s_hburst_i, s_hprot_i, s_hmastlock_i};
  assign off       = s_haddr_i - BASE;
  assign accept    = s_hsel_i & s_htrans_i[1] & s_hready_i;

`ifdef AHB_RESP_RANDWAIT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign load   = lfsr_q[3:0] & WAITS_L;

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) lfsr_q <= 16'hACE1;
    else             lfsr_q <= lfsr_d;
  end
`else
  assign load = WAITS_L;
`endif

  always_comb begin
    legal = (off < SPAN);
    be_in = '0;
    unique case (s_hsize_i)
      3'd0: be_in = 4'b0001 << s_haddr_i[1:0];
      3'd1: begin
        be_in = s_haddr_i[1] ? 4'b1100 : 4'b0011;
        if (s_haddr_i[0]) legal = 1'b0;
      end
      3'd2: begin
        be_in = '1;
        if (s_haddr_i[1:0] != 2'b00) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  // IDLE, DATA and ERR2 all end a data phase, so each evaluates a new accept the same way.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q <= 4'd1) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = off[AW+1:2];
          be_d    = be_in;
          write_d = s_hwrite_i;
          if (!legal) begin
            state_d = S_ERR1;
          end else if (load == 4'd0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = load;
          end
        end
      end
    endcase
    hreadyout_d = !(state_d inside {S_WAIT, S_ERR1});
    hresp_d     = state_d inside {S_ERR1, S_ERR2};
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      be_q        <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      be_q        <= be_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (state_q == S_DATA && write_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= s_hwdata_i[8*i +: 8];
      end
    end
  end

  assign s_hrdata_o    = (state_q == S_DATA) ? mem[idx_q] : '0;
  assign s_hreadyout_o = hreadyout_q;
  assign s_hresp_o     = hresp_q;

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Directed bench for ahb_sram_responder: zero-wait vector table plus wait-state and reset sequences.
module tb_ahb_sram_responder;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TB = 2'b01;
  localparam logic [1:0] TN = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel0, sel3, sel4;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] rd0, rd3, rd4;
  logic        ro0, ro3, ro4;
  logic        rp0, rp3, rp4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahb_sram_responder #(.DEPTH(16), .BASE(32'h0), .WAITS(0)) u0 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_hsel_i(sel0), .s_haddr_i(haddr),
    .s_htrans_i(htrans), .s_hwrite_i(hwrite), .s_hsize_i(hsize), .s_hburst_i(hburst),
    .s_hprot_i(hprot), .s_hmastlock_i(hmastlock), .s_hwdata_i(hwdata), .s_hready_i(hready),
    .s_hrdata_o(rd0), .s_hreadyout_o(ro0), .s_hresp_o(rp0));

  ahb_sram_responder #(.DEPTH(16), .BASE(32'h0), .WAITS(3)) u3 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_hsel_i(sel3), .s_haddr_i(haddr),
    .s_htrans_i(htrans), .s_hwrite_i(hwrite), .s_hsize_i(hsize), .s_hburst_i(hburst),
    .s_hprot_i(hprot), .s_hmastlock_i(hmastlock), .s_hwdata_i(hwdata), .s_hready_i(hready),
    .s_hrdata_o(rd3), .s_hreadyout_o(ro3), .s_hresp_o(rp3));

  ahb_sram_responder #(.DEPTH(16), .BASE(32'h0), .WAITS(4)) u4 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_hsel_i(sel4), .s_haddr_i(haddr),
    .s_htrans_i(htrans), .s_hwrite_i(hwrite), .s_hsize_i(hsize), .s_hburst_i(hburst),
    .s_hprot_i(hprot), .s_hmastlock_i(hmastlock), .s_hwdata_i(hwdata), .s_hready_i(hready),
    .s_hrdata_o(rd4), .s_hreadyout_o(ro4), .s_hresp_o(rp4));

  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic        rdy;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        e_rdy;
    logic        e_resp;
    logic        cd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[26];

  function automatic vec_t v(logic sel, logic [1:0] tr, logic rdy, logic wr, logic [2:0] sz,
                             logic [31:0] a, logic [31:0] wd, logic er, logic ep, logic cd,
                             logic [31:0] ed);
    vec_t r;
    r.sel = sel; r.tr = tr; r.rdy = rdy; r.wr = wr; r.sz = sz; r.a = a; r.wd = wd;
    r.e_rdy = er; r.e_resp = ep; r.cd = cd; r.e_data = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts low-hreadyout cycles after the next accept edge; returns at the negedge of the DATA cycle.
  task automatic wait_ready(input int which, output int lows);
    logic r;
    lows = 0;
    @(negedge clk);
    r = (which == 3) ? ro3 : ro4;
    while (r !== 1'b1 && lows < 20) begin
      lows++;
      @(negedge clk);
      r = (which == 3) ? ro3 : ro4;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lows;

    // row: sel trans rdy wr size addr wdata | exp_ready exp_resp check_data exp_data
    vt[0]  = v(0, TI, 1, 0, 0, 32'h00, 32'h0,         1, 0, 1, 32'h0);
    vt[1]  = v(1, TN, 1, 1, 2, 32'h10, 32'h0,         1, 0, 1, 32'h0);
    vt[2]  = v(1, TN, 1, 0, 2, 32'h10, 32'hDEADBEEF,  1, 0, 0, 32'h0);
    vt[3]  = v(0, TI, 1, 0, 0, 32'h00, 32'h0,         1, 0, 1, 32'hDEADBEEF);
    vt[4]  = v(1, TN, 1, 1, 2, 32'h10, 32'h0,         1, 0, 1, 32'h0);
    vt[5]  = v(1, TN, 1, 1, 0, 32'h12, 32'h11223344,  1, 0, 1, 32'hDEADBEEF);
    vt[6]  = v(1, TN, 1, 0, 2, 32'h10, 32'hA55AC33C,  1, 0, 1, 32'h11223344);
    vt[7]  = v(0, TI, 1, 0, 0, 32'h00, 32'h0,         1, 0, 1, 32'h115A3344);
    vt[8]  = v(1, TN, 1, 1, 1, 32'h13, 32'h0,         1, 0, 1, 32'h0);
    vt[9]  = v(0, TI, 1, 0, 0, 32'h00, 32'hFFFFFFFF,  0, 1, 1, 32'h0);
    vt[10] = v(0, TI, 1, 0, 0, 32'h00, 32'hFFFFFFFF,  1, 1, 1, 32'h0);
    vt[11] = v(1, TN, 1, 0, 2, 32'h40, 32'h0,         1, 0, 1, 32'h0);
    vt[12] = v(0, TI, 1, 0, 0, 32'h00, 32'h0,         0, 1, 1, 32'h0);
    vt[13] = v(1, TN, 1, 0, 2, 32'h10, 32'h0,         1, 1, 1, 32'h0);
    vt[14] = v(1, TN, 1, 1, 2, 32'h20, 32'h0,         1, 0, 1, 32'h115A3344);
    vt[15] = v(1, TN, 1, 0, 2, 32'h20, 32'hCAFEF00D,  1, 0, 0, 32'h0);
    vt[16] = v(0, TI, 1, 0, 0, 32'h00, 32'h0,         1, 0, 1, 32'hCAFEF00D);
    vt[17] = v(1, TN, 1, 0, 3, 32'h10, 32'h0,         1, 0, 1, 32'h0);
    vt[18] = v(0, TI, 1, 0, 0, 32'h00, 32'h0,         0, 1, 1, 32'h0);
    vt[19] = v(1, TB, 1, 0, 0, 32'h11, 32'h0,         1, 1, 1, 32'h0);
    vt[20] = v(0, TN, 1, 0, 2, 32'h10, 32'h0,         1, 0, 1, 32'h0);
    vt[21] = v(1, TN, 0, 0, 2, 32'h10, 32'h0,         1, 0, 1, 32'h0);
    vt[22] = v(1, TN, 1, 0, 1, 32'h12, 32'h0,         1, 0, 1, 32'h0);
    vt[23] = v(1, TN, 1, 0, 0, 32'h10, 32'h0,         1, 0, 1, 32'h115A3344);
    vt[24] = v(0, TI, 1, 0, 0, 32'h00, 32'h0,         1, 0, 1, 32'h115A3344);
    vt[25] = v(0, TI, 1, 0, 0, 32'h00, 32'h0,         1, 0, 1, 32'h0);

    rst_n = 1'b0;
    sel0 = 1'b0; sel3 = 1'b0; sel4 = 1'b0;
    haddr = '0; htrans = TI; hwrite = 1'b0; hsize = 3'd2;
    hburst = '0; hprot = '0; hmastlock = 1'b0; hwdata = '0; hready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("reset_hreadyout", {31'b0, ro0}, 32'h1);
    chk("reset_hresp", {31'b0, rp0}, 32'h0);
    chk("reset_hrdata", rd0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(posedge clk);
      #1;
      sel0 = vt[i].sel; htrans = vt[i].tr; hready = vt[i].rdy; hwrite = vt[i].wr;
      hsize = vt[i].sz; haddr = vt[i].a; hwdata = vt[i].wd;
      @(negedge clk);
      chk($sformatf("vec%0d_hreadyout", i), {31'b0, ro0}, {31'b0, vt[i].e_rdy});
      chk($sformatf("vec%0d_hresp", i), {31'b0, rp0}, {31'b0, vt[i].e_resp});
      if (vt[i].cd) chk($sformatf("vec%0d_hrdata", i), rd0, vt[i].e_data);
    end

    // Three-wait instance: write, then two back-to-back reads held on the bus.
    sel0 = 1'b0; hready = 1'b1;
    sel3 = 1'b1; htrans = TN; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h8; hwdata = 32'h12345678;
    wait_ready(3, lows);
    chk("w3_write_waits", 32'(lows), 32'd3);
    chk("w3_write_hresp", {31'b0, rp3}, 32'h0);
    hwrite = 1'b0;
    wait_ready(3, lows);
    chk("w3_read1_waits", 32'(lows), 32'd3);
    chk("w3_read1_data", rd3, 32'h12345678);
    chk("w3_read1_hresp", {31'b0, rp3}, 32'h0);
    wait_ready(3, lows);
    chk("w3_read2_waits", 32'(lows), 32'd3);
    chk("w3_read2_data", rd3, 32'h12345678);
    sel3 = 1'b0; htrans = TI;
    @(negedge clk);
    chk("w3_idle_hreadyout", {31'b0, ro3}, 32'h1);
    chk("w3_idle_hrdata", rd3, 32'h0);

    // Four-wait instance: reset in the middle of a write's wait period.
    sel4 = 1'b1; htrans = TN; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h4; hwdata = 32'hA5A5A5A5;
    wait_ready(4, lows);
    chk("w4_write_waits", 32'(lows), 32'd4);
    @(posedge clk);
    #1;
    sel4 = 1'b0; htrans = TI; hwdata = 32'h0BADF00D;
    @(negedge clk);
    @(negedge clk);
    chk("w4_pre_reset_hreadyout", {31'b0, ro4}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("w4_reset_hreadyout", {31'b0, ro4}, 32'h1);
    chk("w4_reset_hresp", {31'b0, rp4}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sel4 = 1'b1; htrans = TN; hwrite = 1'b0; haddr = 32'h4;
    wait_ready(4, lows);
    chk("w4_read_waits", 32'(lows), 32'd4);
    chk("w4_read_data_kept", rd4, 32'hA5A5A5A5);
    chk("w4_read_hresp", {31'b0, rp4}, 32'h0);
    sel4 = 1'b0; htrans = TI;
    @(negedge clk);
    chk("w4_idle_hreadyout", {31'b0, ro4}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
